// File: rtl/pifo_stfq_client.sv
// pifo_stfq_client: STFQ ranking client that pushes into and pops from a PIFO, never both in one cycle.
// Optional push/pop/saturation counters are enabled with PIFO_CLIENT_STATS_EN.
module pifo_stfq_client #(
    parameter int NUM_FLOWS    = 4,
    parameter int MAX_PRIORITY = 256,
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 8,
    localparam int FLOW_WIDTH  = $clog2(NUM_FLOWS),
    localparam int PRIO_WIDTH  = $clog2(MAX_PRIORITY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__clear,
    input  logic                  i__pkt_valid,
    input  logic [FLOW_WIDTH-1:0] i__pkt_flow,
    input  logic [LEN_WIDTH-1:0]  i__pkt_len,
    input  logic [DATA_WIDTH-1:0] i__pkt_data,
    output logic                  o__pkt_ready,
    output logic                  o__pifo_in_valid,
    output logic [PRIO_WIDTH-1:0] o__pifo_in_priority,
    output logic [DATA_WIDTH-1:0] o__pifo_in_data,
    input  logic                  i__pifo_in_ready,
    input  logic                  i__pifo_out_valid,
    input  logic [PRIO_WIDTH-1:0] i__pifo_out_priority,
    input  logic [DATA_WIDTH-1:0] i__pifo_out_data,
    output logic                  o__pifo_out_ready,
    output logic                  o__pifo_clear_all,
    output logic                  o__deq_valid,
    output logic [PRIO_WIDTH-1:0] o__deq_priority,
    output logic [DATA_WIDTH-1:0] o__deq_data,
    input  logic                  i__deq_ready
`ifdef PIFO_CLIENT_STATS_EN
   ,output logic [31:0]           o__push_count,
    output logic [31:0]           o__pop_count,
    output logic [31:0]           o__sat_count
`endif
);
    localparam int SW = (PRIO_WIDTH > LEN_WIDTH ? PRIO_WIDTH : LEN_WIDTH) + 1;
    localparam logic [SW-1:0] TOP = SW'(MAX_PRIORITY - 1);

    logic [PRIO_WIDTH-1:0] finish [NUM_FLOWS];
    logic [PRIO_WIDTH-1:0] vtime, start, finish_cur, next_finish;
    logic [SW-1:0]         sum;
    logic                  hold_valid, rr, en, push_req, pop_req, push_grant, pop_grant, accept, clamp;

    // Reset and clear both block every handshake in their cycle.
    always_comb begin
        en          = ~reset & ~i__clear;
        push_req    = hold_valid & i__pifo_in_ready;
        pop_req     = i__pifo_out_valid & (~o__deq_valid | i__deq_ready);
        push_grant  = en & push_req & (~pop_req | ~rr);
        pop_grant   = en & pop_req & (~push_req | rr);
        o__pkt_ready = en & (~hold_valid | push_grant);
        accept      = i__pkt_valid & o__pkt_ready;
        finish_cur  = finish[i__pkt_flow];
        start       = finish_cur > vtime ? finish_cur : vtime;
        sum         = SW'(start) + SW'(i__pkt_len);
        clamp       = sum > TOP;
        next_finish = clamp ? PRIO_WIDTH'(TOP) : sum[PRIO_WIDTH-1:0];
    end

    assign o__pifo_in_valid  = hold_valid & push_grant;
    assign o__pifo_out_ready = pop_grant;
    assign o__pifo_clear_all = i__clear & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FLOWS; i++) finish[i] <= '0;
            vtime               <= '0;
            rr                  <= 1'b0;
            hold_valid          <= 1'b0;
            o__pifo_in_priority <= '0;
            o__pifo_in_data     <= '0;
            o__deq_valid        <= 1'b0;
            o__deq_priority     <= '0;
            o__deq_data         <= '0;
        end else if (i__clear) begin
            for (int i = 0; i < NUM_FLOWS; i++) finish[i] <= '0;
            vtime               <= '0;
            rr                  <= 1'b0;
            hold_valid          <= 1'b0;
            o__pifo_in_priority <= '0;
            o__pifo_in_data     <= '0;
            o__deq_valid        <= 1'b0;
            o__deq_priority     <= '0;
            o__deq_data         <= '0;
        end else begin
            if (accept) begin
                finish[i__pkt_flow] <= next_finish;
                hold_valid          <= 1'b1;
                o__pifo_in_priority <= start;
                o__pifo_in_data     <= i__pkt_data;
            end else if (push_grant) begin
                hold_valid <= 1'b0;
            end
            if (pop_grant) begin
                o__deq_valid    <= 1'b1;
                o__deq_priority <= i__pifo_out_priority;
                o__deq_data     <= i__pifo_out_data;
                vtime           <= i__pifo_out_priority > vtime ? i__pifo_out_priority : vtime;
            end else if (o__deq_valid & i__deq_ready) begin
                o__deq_valid <= 1'b0;
            end
            if (push_req & pop_req) rr <= ~rr;
        end
    end

`ifdef PIFO_CLIENT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o__push_count <= '0;
            o__pop_count  <= '0;
            o__sat_count  <= '0;
        end else if (i__clear) begin
            o__push_count <= '0;
            o__pop_count  <= '0;
            o__sat_count  <= '0;
        end else begin
            o__push_count <= o__push_count + 32'(o__pifo_in_valid);
            o__pop_count  <= o__pop_count + 32'(pop_grant);
            o__sat_count  <= o__sat_count + 32'(accept & clamp);
        end
    end
`endif
endmodule

// File: tb/tb_pifo_stfq_client.sv
// tb_pifo_stfq_client: directed checks of STFQ ranking, push/pop arbitration, saturation and clear.
module tb_pifo_stfq_client;
    logic       clk = 1'b0, reset = 1'b1, i__clear = 1'b0;
    logic       i__pkt_valid = 1'b0;
    logic [1:0] i__pkt_flow = '0;
    logic [7:0] i__pkt_len = '0, i__pkt_data = '0;
    logic       o__pkt_ready, o__pifo_in_valid, o__pifo_out_ready, o__pifo_clear_all, o__deq_valid;
    logic [7:0] o__pifo_in_priority, o__pifo_in_data, o__deq_priority, o__deq_data;
    logic       i__pifo_in_ready = 1'b1, i__pifo_out_valid = 1'b0, i__deq_ready = 1'b0;
    logic [7:0] i__pifo_out_priority = '0, i__pifo_out_data = '0;
`ifdef PIFO_CLIENT_STATS_EN
    logic [31:0] o__push_count, o__pop_count, o__sat_count;
`endif
    int checks = 0, errors = 0;
    logic [3:0] exp_push = 4'b0101;

    always #5 clk = ~clk;

    pifo_stfq_client dut (
        .clk(clk), .reset(reset), .i__clear(i__clear),
        .i__pkt_valid(i__pkt_valid), .i__pkt_flow(i__pkt_flow), .i__pkt_len(i__pkt_len),
        .i__pkt_data(i__pkt_data), .o__pkt_ready(o__pkt_ready),
        .o__pifo_in_valid(o__pifo_in_valid), .o__pifo_in_priority(o__pifo_in_priority),
        .o__pifo_in_data(o__pifo_in_data), .i__pifo_in_ready(i__pifo_in_ready),
        .i__pifo_out_valid(i__pifo_out_valid), .i__pifo_out_priority(i__pifo_out_priority),
        .i__pifo_out_data(i__pifo_out_data), .o__pifo_out_ready(o__pifo_out_ready),
        .o__pifo_clear_all(o__pifo_clear_all), .o__deq_valid(o__deq_valid),
        .o__deq_priority(o__deq_priority), .o__deq_data(o__deq_data), .i__deq_ready(i__deq_ready)
`ifdef PIFO_CLIENT_STATS_EN
       ,.o__push_count(o__push_count), .o__pop_count(o__pop_count), .o__sat_count(o__sat_count)
`endif
    );

    // Push and pop must never be requested of the PIFO together.
    always @(negedge clk)
        if (!reset) begin
            checks++;
            assert (!(o__pifo_in_valid && o__pifo_out_ready)) else begin
                errors++;
                $error("FAIL excl observed in_valid=%0d out_ready=%0d expected not both", o__pifo_in_valid, o__pifo_out_ready);
            end
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic v, input logic [1:0] f, input logic [7:0] l, input logic [7:0] d);
        i__pkt_valid = v;
        i__pkt_flow  = f;
        i__pkt_len   = l;
        i__pkt_data  = d;
    endtask

    initial begin
        i__pifo_out_valid = 1'b1;
        #2;
        chk("rst_ready", o__pkt_ready, 0);
        chk("rst_in_valid", o__pifo_in_valid, 0);
        chk("rst_out_ready", o__pifo_out_ready, 0);
        chk("rst_deq_valid", o__deq_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        i__pifo_out_valid = 1'b0;
        #1 chk("idle_ready", o__pkt_ready, 1);

        pkt(1, 0, 10, 8'hA1);
        #1 chk("t1_ready", o__pkt_ready, 1);
        tick; pkt(0, 0, 0, 0);
        #1 chk("t1_in_valid", o__pifo_in_valid, 1);
        chk("t1_prio", o__pifo_in_priority, 0);
        chk("t1_data", o__pifo_in_data, 8'hA1);
        tick;
        #1 chk("t1_pushed", o__pifo_in_valid, 0);

        i__clear = 1'b1; pkt(1, 0, 5, 8'h11);
        #1 chk("clr_all", o__pifo_clear_all, 1);
        chk("clr_ready", o__pkt_ready, 0);
        tick; i__clear = 1'b0;
        pkt(1, 0, 10, 8'hB1);
        #1 chk("clr_done", o__pifo_clear_all, 0);
        tick; pkt(1, 0, 10, 8'hB2);
        #1 chk("b2b_prio0", o__pifo_in_priority, 0);
        chk("b2b_ready", o__pkt_ready, 1);
        tick; pkt(1, 1, 5, 8'hC1);
        #1 chk("b2b_prio10", o__pifo_in_priority, 10);
        chk("b2b_data", o__pifo_in_data, 8'hB2);
        tick; pkt(0, 0, 0, 0);
        #1 chk("flow1_prio", o__pifo_in_priority, 0);
        chk("flow1_data", o__pifo_in_data, 8'hC1);
        tick;

        i__pifo_out_valid = 1'b1; i__pifo_out_priority = 40; i__pifo_out_data = 8'hD1;
        #1 chk("pop_ready", o__pifo_out_ready, 1);
        tick; i__pifo_out_valid = 1'b0; pkt(1, 2, 3, 8'hE1);
        #1 chk("deq_valid", o__deq_valid, 1);
        chk("deq_prio40", o__deq_priority, 40);
        chk("deq_data", o__deq_data, 8'hD1);
        tick; pkt(0, 0, 0, 0);
        #1 chk("vtime_prio", o__pifo_in_priority, 40);
        chk("vtime_push", o__pifo_in_valid, 1);
        tick;

        i__pifo_out_valid = 1'b1; i__pifo_out_priority = 50; i__pifo_out_data = 8'hD2;
        #1 chk("full_nopop", o__pifo_out_ready, 0);
        tick;
        #1 chk("hold_prio", o__deq_priority, 40);
        chk("hold_data", o__deq_data, 8'hD1);
        chk("hold_nopop", o__pifo_out_ready, 0);
        i__deq_ready = 1'b1;
        #1 chk("refill_pop", o__pifo_out_ready, 1);
        tick; i__pifo_out_valid = 1'b0;
        #1 chk("refill_prio", o__deq_priority, 50);
        chk("refill_valid", o__deq_valid, 1);
        tick; i__deq_ready = 1'b0;
        #1 chk("drain_valid", o__deq_valid, 0);

        i__pifo_out_valid = 1'b1; i__pifo_out_priority = 60; i__pifo_out_data = 8'hF1;
        i__deq_ready = 1'b1; pkt(1, 3, 1, 8'h33);
        #1 chk("alt_first_pop", o__pifo_out_ready, 1);
        chk("alt_first_nopush", o__pifo_in_valid, 0);
        tick;
        for (int i = 0; i < 4; i++) begin
            #1 chk("alt_push", o__pifo_in_valid, 32'(exp_push[i]));
            chk("alt_pop", o__pifo_out_ready, 32'(!exp_push[i]));
            if (i == 0) chk("alt_prio50", o__pifo_in_priority, 50);
            if (i == 2) chk("alt_prio60", o__pifo_in_priority, 60);
            tick;
        end
        i__pifo_out_valid = 1'b0; pkt(0, 0, 0, 0);
        #1 chk("alt_last_push", o__pifo_in_valid, 1);
        chk("alt_prio61", o__pifo_in_priority, 61);
        tick;
        #1 chk("alt_deq_empty", o__deq_valid, 0);
        i__deq_ready = 1'b0;

        pkt(1, 1, 190, 8'h51);
        tick; pkt(1, 1, 20, 8'h52);
        #1 chk("sat_prio60", o__pifo_in_priority, 60);
        tick; pkt(1, 1, 1, 8'h53);
        #1 chk("sat_prio250", o__pifo_in_priority, 250);
`ifdef PIFO_CLIENT_STATS_EN
        chk("sat_count", o__sat_count, 1);
`endif
        tick; pkt(0, 0, 0, 0);
        #1 chk("sat_prio255", o__pifo_in_priority, 255);
        tick;

        i__pifo_in_ready = 1'b0; pkt(1, 0, 7, 8'h61);
        #1 chk("stall_accept", o__pkt_ready, 1);
        tick; pkt(1, 0, 7, 8'h62);
        #1 chk("stall_ready", o__pkt_ready, 0);
        chk("stall_in_valid", o__pifo_in_valid, 0);
        tick;
        i__clear = 1'b1; i__pifo_in_ready = 1'b1; i__pifo_out_valid = 1'b1;
        #1 chk("clr2_all", o__pifo_clear_all, 1);
        chk("clr2_ready", o__pkt_ready, 0);
        chk("clr2_in_valid", o__pifo_in_valid, 0);
        chk("clr2_out_ready", o__pifo_out_ready, 0);
        tick; i__clear = 1'b0; i__pifo_out_valid = 1'b0; pkt(1, 2, 4, 8'h71);
        #1 chk("clr2_done", o__pifo_clear_all, 0);
        chk("clr2_hold_gone", o__pifo_in_valid, 0);
        chk("clr2_deq_gone", o__deq_valid, 0);
        tick; pkt(0, 0, 0, 0);
        #1 chk("clr2_prio0", o__pifo_in_priority, 0);
        chk("clr2_data", o__pifo_in_data, 8'h71);
`ifdef PIFO_CLIENT_STATS_EN
        chk("clr2_push_count", o__push_count, 0);
`endif
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
